// File: rtl/iiitb_sdm_arb_ctrl.sv
// Two-requester round-robin front end for one serial "1010" overlapping Mealy detector.
// Latency: accept at cycle t, W shift cycles t+1..t+W, res_valid from t+W+1; period W+2.
// Backpressure: no grants while a result waits for res_ready; requesters hold valid/data.
//
// Ports:
//   clk, reset            : single clock, synchronous active-high reset
//   req0_* / req1_*       : word requesters (valid/data in, ready out, combinational in IDLE)
//   res_valid/res_ready   : result handshake; res_id, res_count, res_mask held until taken
//   busy                  : high whenever the controller is not idle
//
// Optional macro SDM_CARRY_EN: keeps a per-requester detector context so that
// patterns can span consecutive words of the same requester.
module iiitb_sdm_arb_ctrl #(
    parameter int W    = 8,
    parameter int CNTW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    input  logic [W-1:0]    req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [W-1:0]    req1_data,
    output logic            req1_ready,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_id,
    output logic [CNTW-1:0] res_count,
    output logic [W-1:0]    res_mask,
    output logic            busy
);

    localparam int IDXW = $clog2(W);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_RESULT = 2'd2;

    // Detector states: longest suffix of the bit stream that is a prefix of "1010".
    localparam logic [1:0] DS_S0 = 2'd0;
    localparam logic [1:0] DS_S1 = 2'd1;
    localparam logic [1:0] DS_S2 = 2'd2;
    localparam logic [1:0] DS_S3 = 2'd3;

    localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(W - 1);

    logic [1:0]      state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic [W-1:0]    data_q, data_d;
    logic            id_q, id_d;
    logic [1:0]      det_q, det_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [W-1:0]    mask_q, mask_d;

    logic            gnt0, gnt1;
    logic            bit_in, hit;
    logic [1:0]      det_next;
    logic [1:0]      det_start;

`ifdef SDM_CARRY_EN
    logic [1:0]      ctx0_q, ctx0_d;
    logic [1:0]      ctx1_q, ctx1_d;
`endif

    // Round-robin grant; only evaluated in IDLE and suppressed during reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if ((state_q == ST_IDLE) && !reset) begin
            gnt0 = req0_valid && (!req1_valid || last_grant_q);
            gnt1 = req1_valid && (!req0_valid || !last_grant_q);
        end
    end

    // The word register shifts left, so the MSB is always the next bit to feed.
    always_comb begin
        bit_in   = data_q[W-1];
        hit      = 1'b0;
        det_next = det_q;
        case (det_q)
            DS_S0:   det_next = bit_in ? DS_S1 : DS_S0;
            DS_S1:   det_next = bit_in ? DS_S1 : DS_S2;
            DS_S2:   det_next = bit_in ? DS_S3 : DS_S0;
            default: begin
                det_next = bit_in ? DS_S1 : DS_S2;
                hit      = ~bit_in;
            end
        endcase
    end

`ifdef SDM_CARRY_EN
    assign det_start = gnt1 ? ctx1_q : ctx0_q;
`else
    assign det_start = DS_S0;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        id_d         = id_q;
        det_d        = det_q;
        idx_d        = idx_q;
        count_d      = count_q;
        mask_d       = mask_q;
`ifdef SDM_CARRY_EN
        ctx0_d       = ctx0_q;
        ctx1_d       = ctx1_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (gnt0 || gnt1) begin
                    data_d  = gnt1 ? req1_data : req0_data;
                    id_d    = gnt1;
                    det_d   = det_start;
                    idx_d   = '0;
                    count_d = '0;
                    mask_d  = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                data_d = data_q << 1;
                det_d  = det_next;
                idx_d  = idx_q + IDXW'(1);
                // Shifting hits in at the LSB lands the hit for bit index k on
                // mask position W-1-k once all W bits have gone through.
                mask_d = {mask_q[W-2:0], hit};
                if (hit && (count_q != CNT_MAX)) begin
                    count_d = count_q + CNTW'(1);
                end
                if (idx_q == IDX_LAST) begin
                    state_d = ST_RESULT;
`ifdef SDM_CARRY_EN
                    if (id_q) begin
                        ctx1_d = det_next;
                    end else begin
                        ctx0_d = det_next;
                    end
`endif
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    last_grant_d = id_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            data_q       <= '0;
            id_q         <= 1'b0;
            det_q        <= DS_S0;
            idx_q        <= '0;
            count_q      <= '0;
            mask_q       <= '0;
`ifdef SDM_CARRY_EN
            ctx0_q       <= DS_S0;
            ctx1_q       <= DS_S0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            id_q         <= id_d;
            det_q        <= det_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            mask_q       <= mask_d;
`ifdef SDM_CARRY_EN
            ctx0_q       <= ctx0_d;
            ctx1_q       <= ctx1_d;
`endif
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign res_valid  = (state_q == ST_RESULT);
    assign res_id     = id_q;
    assign res_count  = count_q;
    assign res_mask   = mask_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iiitb_sdm_arb_ctrl.sv
// Bench for iiitb_sdm_arb_ctrl: directed scenarios plus randomized words.
// Reference model scans a 4-bit sliding window of each requester's bit stream.
// Outputs are sampled 1 time unit after the falling edge; inputs change on the falling edge.
module tb_iiitb_sdm_arb_ctrl;

    localparam int W    = 8;
    localparam int CNTW = 4;
    localparam int MAXC = (1 << CNTW) - 1;
`ifdef SDM_CARRY_EN
    localparam bit CARRY = 1'b1;
`else
    localparam bit CARRY = 1'b0;
`endif
    localparam int BOUND = 100;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            req0_valid = 1'b0;
    logic [W-1:0]    req0_data = '0;
    logic            req0_ready;
    logic            req1_valid = 1'b0;
    logic [W-1:0]    req1_data = '0;
    logic            req1_ready;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic            res_id;
    logic [CNTW-1:0] res_count;
    logic [W-1:0]    res_mask;
    logic            busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [3:0] hist [2];

    iiitb_sdm_arb_ctrl #(.W(W), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_count(res_count), .res_mask(res_mask), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A detection completes on a bit exactly when the last four stream bits are 1010.
    task automatic model_word(input int id, input logic [W-1:0] d,
                              output logic [CNTW-1:0] ecnt, output logic [W-1:0] emask);
        int c;
        logic [3:0] h;
        c = 0;
        h = CARRY ? hist[id] : 4'b0000;
        emask = '0;
        for (int i = 0; i < W; i++) begin
            h = {h[2:0], d[W-1-i]};
            if (h == 4'b1010) begin
                emask[W-1-i] = 1'b1;
                c++;
            end
        end
        if (c > MAXC) c = MAXC;
        ecnt = CNTW'(c);
        hist[id] = h;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hist[0] = 4'b0;
        hist[1] = 4'b0;
    endtask

    // Offers one word, waits for grant and result, holds res_ready low for 'hold' cycles.
    task automatic do_word(input int id, input logic [W-1:0] d, input int hold,
                           output int wt, output int lat, output logic rid,
                           output logic [CNTW-1:0] rcnt, output logic [W-1:0] rmask,
                           output bit to);
        int tg;
        int k;
        to = 1'b0; lat = -1; wt = -1; rid = 1'b0; rcnt = '0; rmask = '0;
        @(negedge clk);
        if (id == 0) begin req0_valid = 1'b1; req0_data = d; end
        else begin req1_valid = 1'b1; req1_data = d; end
        #1;
        k = 0;
        while (!((id == 0) ? req0_ready : req1_ready) && k < BOUND) begin
            @(negedge clk); #1; k++;
        end
        if (k >= BOUND) begin
            to = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        wt = k;
        tg = cyc;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = ~d; req1_data = ~d;
        #1;
        k = 0;
        while (!res_valid && k < BOUND) begin
            @(negedge clk); #1; k++;
        end
        if (k >= BOUND) begin
            to = 1'b1;
            return;
        end
        lat = cyc - tg;
        rid = res_id; rcnt = res_count; rmask = res_mask;
        repeat (hold) @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        vectors++;
        if ({res_valid, busy, res_id} !== 3'b000 || res_count !== '0 || res_mask !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b b=%b id=%b c=%h m=%h expected all 0",
                     res_valid, busy, res_id, res_count, res_mask);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        hist[0] = 4'b0;
        hist[1] = 4'b0;
    endtask

    task automatic test_basic();
        int wt, lat;
        logic rid;
        logic [CNTW-1:0] rc;
        logic [W-1:0] rm;
        bit to;
        do_reset();
        do_word(0, 8'b1010_1010, 0, wt, lat, rid, rc, rm, to);
        vectors++;
        if (to || wt !== 0 || lat !== W + 1) begin
            miscompares++;
            $display("FAIL basic_timing: got to=%0d wait=%0d lat=%0d expected 0/0/%0d", to, wt, lat, W + 1);
        end
        vectors++;
        if (rid !== 1'b0 || rc !== 4'd3 || rm !== 8'b0001_0101) begin
            miscompares++;
            $display("FAIL basic_aa: got id=%b c=%0d m=%b expected 0/3/00010101", rid, rc, rm);
        end
        do_word(1, 8'b1101_0011, 1, wt, lat, rid, rc, rm, to);
        vectors++;
        if (to || rid !== 1'b1 || rc !== 4'd1 || rm !== 8'b0000_1000) begin
            miscompares++;
            $display("FAIL basic_d3: got to=%0d id=%b c=%0d m=%b expected 1/1/00001000", to, rid, rc, rm);
        end
        do_word(1, 8'h00, 0, wt, lat, rid, rc, rm, to);
        vectors++;
        if (to || rid !== 1'b1 || rc !== 4'd0 || rm !== 8'h00) begin
            miscompares++;
            $display("FAIL basic_00: got to=%0d id=%b c=%0d m=%b expected 1/0/0", to, rid, rc, rm);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d0, d1;
        bit pend0, pend1, armed;
        int ngr, nres, streak, gid;
        logic [CNTW-1:0] ec;
        logic [W-1:0] em;
        int qid[$];
        logic [CNTW-1:0] qc[$];
        logic [W-1:0] qm[$];
        do_reset();
        ngr = 0; nres = 0; streak = 0; armed = 1'b0; pend0 = 1'b0; pend1 = 1'b0;
        @(negedge clk);
        d0 = W'($urandom); d1 = W'($urandom);
        req0_data = d0; req1_data = d1;
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        for (int k = 0; k < 12 * (W + 2) && nres < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (pend0) begin d0 = W'($urandom); req0_data = d0; pend0 = 1'b0; end
            if (pend1) begin d1 = W'($urandom); req1_data = d1; pend1 = 1'b0; end
            #1;
            if (req0_ready && req1_ready) begin
                vectors++; miscompares++;
                $display("FAIL b2b_two_ready: got 11 expected at most one");
            end
            if (armed) begin
                if (!busy) streak++;
                else begin
                    vectors++;
                    if (streak !== 1) begin
                        miscompares++;
                        $display("FAIL b2b_idle_gap: got %0d idle cycles expected 1", streak);
                    end
                    armed = 1'b0;
                end
            end
            if (req0_ready || req1_ready) begin
                gid = req1_ready ? 1 : 0;
                vectors++;
                if (gid !== ngr % 2) begin
                    miscompares++;
                    $display("FAIL b2b_order: grant %0d got id %0d expected %0d", ngr, gid, ngr % 2);
                end
                model_word(gid, gid ? d1 : d0, ec, em);
                qid.push_back(gid); qc.push_back(ec); qm.push_back(em);
                ngr++;
                if (gid == 1) pend1 = 1'b1; else pend0 = 1'b1;
            end
            if (res_valid && qid.size() > 0) begin
                gid = qid.pop_front(); ec = qc.pop_front(); em = qm.pop_front();
                vectors++;
                if (res_id !== gid[0] || res_count !== ec || res_mask !== em) begin
                    miscompares++;
                    $display("FAIL b2b_result: got id=%b c=%h m=%h expected id=%0d c=%h m=%h",
                             res_id, res_count, res_mask, gid, ec, em);
                end
                nres++;
                armed = 1'b1;
                streak = 0;
            end
        end
        vectors++;
        if (nres < 8) begin
            miscompares++;
            $display("FAIL b2b_timeout: got %0d results expected 8", nres);
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int k;
        logic [CNTW-1:0] ec;
        logic [W-1:0] em;
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 8'b1010_1010;
        #1;
        k = 0;
        while (!req0_ready && k < BOUND) begin @(negedge clk); #1; k++; end
        model_word(0, 8'b1010_1010, ec, em);
        @(negedge clk);
        req0_data = 8'h5A;
        req1_valid = 1'b1; req1_data = 8'b1101_0011;
        #1;
        k = 0;
        while (!res_valid && k < BOUND) begin @(negedge clk); #1; k++; end
        vectors++;
        if (k >= BOUND) begin
            miscompares++;
            $display("FAIL bp_timeout: got no res_valid expected one");
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            vectors++;
            if (res_valid !== 1'b1 || res_id !== 1'b0 || res_count !== ec || res_mask !== em ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got v=%b id=%b c=%h m=%h r0=%b r1=%b expected 1/0/%h/%h/0/0",
                         i, res_valid, res_id, res_count, res_mask, req0_ready, req1_ready, ec, em);
            end
        end
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        vectors++;
        if (res_valid !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_consume: got v=%b r0=%b r1=%b expected 1/0/0", res_valid, req0_ready, req1_ready);
        end
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_next_grant: got b=%b v=%b r0=%b r1=%b expected 0/0/0/1",
                     busy, res_valid, req0_ready, req1_ready);
        end
        model_word(1, 8'b1101_0011, ec, em);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        k = 0;
        while (!res_valid && k < BOUND) begin @(negedge clk); #1; k++; end
        vectors++;
        if (k >= BOUND || res_id !== 1'b1 || res_count !== ec || res_mask !== em) begin
            miscompares++;
            $display("FAIL bp_second: got id=%b c=%h m=%h expected 1/%h/%h", res_id, res_count, res_mask, ec, em);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int k, tg, seen;
        int wt, lat;
        logic rid;
        logic [CNTW-1:0] rc;
        logic [W-1:0] rm;
        bit to;
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 8'b1010_1010;
        #1;
        k = 0;
        while (!req0_ready && k < BOUND) begin @(negedge clk); #1; k++; end
        tg = cyc;
        @(negedge clk);
        req0_valid = 1'b0;
        while (cyc < tg + 4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hist[0] = 4'b0; hist[1] = 4'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_idle: got b=%b v=%b expected 0/0", busy, res_valid);
        end
        seen = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk); #1;
            if (res_valid) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL mid_reset_noresult: got %0d valid cycles expected 0", seen);
        end
        do_word(0, 8'b1010_1010, 0, wt, lat, rid, rc, rm, to);
        vectors++;
        if (to || rc !== 4'd3 || rm !== 8'b0001_0101) begin
            miscompares++;
            $display("FAIL mid_reset_after: got to=%0d c=%0d m=%b expected 3/00010101", to, rc, rm);
        end
    endtask

    task automatic test_carry();
        int wt, lat;
        logic rid;
        logic [CNTW-1:0] rc;
        logic [W-1:0] rm;
        bit to;
        logic [CNTW-1:0] ec;
        logic [W-1:0] em;
        ec = CARRY ? 4'd1 : 4'd0;
        em = CARRY ? 8'b1000_0000 : 8'b0;
        do_reset();
        do_word(0, 8'b0000_0101, 0, wt, lat, rid, rc, rm, to);
        vectors++;
        if (to || rc !== 4'd0 || rm !== 8'b0) begin
            miscompares++;
            $display("FAIL carry_first: got to=%0d c=%0d m=%b expected 0/0", to, rc, rm);
        end
        do_word(0, 8'b0000_0000, 0, wt, lat, rid, rc, rm, to);
        vectors++;
        if (to || rc !== ec || rm !== em) begin
            miscompares++;
            $display("FAIL carry_second: got to=%0d c=%0d m=%b expected %0d/%b", to, rc, rm, ec, em);
        end
        do_reset();
        do_word(0, 8'b0000_0101, 0, wt, lat, rid, rc, rm, to);
        do_word(1, 8'b0000_1010, 0, wt, lat, rid, rc, rm, to);
        vectors++;
        if (to || rid !== 1'b1 || rc !== 4'd1 || rm !== 8'b0000_0001) begin
            miscompares++;
            $display("FAIL carry_other: got to=%0d id=%b c=%0d m=%b expected 1/1/00000001", to, rid, rc, rm);
        end
        do_word(0, 8'b0000_0000, 0, wt, lat, rid, rc, rm, to);
        vectors++;
        if (to || rid !== 1'b0 || rc !== ec || rm !== em) begin
            miscompares++;
            $display("FAIL carry_interleaved: got to=%0d id=%b c=%0d m=%b expected 0/%0d/%b", to, rid, rc, rm, ec, em);
        end
    endtask

    task automatic test_random();
        int id, wt, lat;
        logic [W-1:0] d;
        logic rid;
        logic [CNTW-1:0] rc, ec;
        logic [W-1:0] rm, em;
        bit to;
        do_reset();
        for (int n = 0; n < 30; n++) begin
            id = $urandom_range(0, 1);
            d = W'($urandom);
            do_word(id, d, $urandom_range(0, 3), wt, lat, rid, rc, rm, to);
            model_word(id, d, ec, em);
            vectors++;
            if (to || lat !== W + 1 || rid !== id[0] || rc !== ec || rm !== em) begin
                miscompares++;
                $display("FAIL random%0d: got to=%0d lat=%0d id=%b c=%h m=%h expected lat=%0d id=%0d c=%h m=%h (data %h)",
                         n, to, lat, rid, rc, rm, W + 1, id, ec, em, d);
            end
        end
    endtask

    initial begin
        hist[0] = 4'b0;
        hist[1] = 4'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_carry();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iiitb_sdm_arb_ctrl.md
Name: iiitb_sdm_arb_ctrl

Overview:
- Shares one serial "1010" overlapping Mealy pattern detector between two word-wide requesters.
- Arbitrates round-robin and accepts one W-bit word per grant.
- Shifts the word MSB-first through the embedded detector, one bit per clock.
- Returns a per-word result (requester id, match count, match-position mask) over a valid/ready handshake. Sits between packet-side word producers and the pattern-statistics consumer.

Parameters:
- W, 8: word width in bits; legal values 4..32.
- CNTW, 4: match-count width; saturating counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  W  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  W  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes result.
- res_id  output  1  requester that owns the result.
- res_count  output  CNTW  number of detections in the word.
- res_mask  output  W  bit i set if a detection completed on data bit i.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset: clk is the only clock; reset is synchronous, active-high.
  - Forces state IDLE, last_grant=1 (req0 wins first), detector state S0.
  - Clears res_valid, res_id, res_count, res_mask and busy to 0.
  - Both reqN_ready are 0 while reset is high.
- FSM states: IDLE, SHIFT, RESULT.
- IDLE:
  - reqN_ready is combinational: high only in IDLE, and only for the granted requester.
  - Only one requester is granted; the loser's ready stays 0.
  - Grant when one valid: that requester.
  - Grant when both valid: the requester != last_grant.
  - On grant: latch data and id, set detector state S0, bit index 0, count 0, mask 0; go to SHIFT.
  - No valid: stay in IDLE.
- SHIFT:
  - Each cycle feed bit b = data[W-1-idx] to the detector.
  - Detector transitions:
    - S0: b=1 -> S1, else S0.
    - S1: b=0 -> S2, else S1.
    - S2: b=1 -> S3, else S0.
    - S3: b=0 -> S2 with detection; b=1 -> S1.
  - On detection: set mask[W-1-idx]; count increments, saturating at 2^CNTW-1.
  - Exactly W cycles in SHIFT, then go to RESULT.
- RESULT:
  - res_valid=1; res_id, res_count and res_mask stay stable until res_ready.
  - On res_valid && res_ready: last_grant <= res_id; go to IDLE; res_valid drops next cycle.
- Latency: handshake at cycle t; SHIFT occupies t+1..t+W; res_valid first high at t+W+1.
  - Minimum per-word period is W+2 cycles (zero-wait res_ready).
- Backpressure: while in RESULT, no grants are made; requesters hold their valid and data.
- Reset mid-operation (any state): the in-flight word is discarded, no result is produced, and the next cycle is IDLE.
- Detections never span words; the detector starts at S0 each word, unless the optional feature below is compiled in.

Optional Feature:
- Macro SDM_CARRY_EN.
- Defined:
  - Two 2-bit context registers ctx0/ctx1, reset to S0.
  - On grant, the detector state is loaded from ctx[id] instead of S0.
  - At the end of SHIFT, the final detector state is written to ctx[id].
  - Patterns therefore span consecutive words of the same requester, and the two streams stay independent.
- Undefined: no context registers; the detector starts at S0 every word.

Test Plan:
- After reset, req0_valid=1, req0_data=8'b1010_1010 -> req0_ready the same cycle; res_valid 9 cycles later with res_id=0, res_count=3, res_mask=8'b0001_0101.
- req1_data=8'b1101_0011 -> res_id=1, res_count=1, res_mask=8'b0000_1000. Then req1_data=8'h00 -> res_count=0, res_mask=0.
- Both valids held high continuously, res_ready=1 -> grant order 0,1,0,1; never two readys in one cycle; busy low exactly one cycle between words.
- res_ready held low 5 cycles in RESULT -> res_valid and outputs stable, req0_ready/req1_ready stay 0; result consumed on the 6th cycle, next grant follows.
- Reset pulsed during SHIFT at bit index 3 -> IDLE next cycle, no res_valid for that word; a following word 8'b1010_1010 gives count=3.
- Two req0 words, 8'b0000_0101 then 8'b0000_0000:
  - Second word with SDM_CARRY_EN: res_count=1, res_mask=8'b1000_0000.
  - Second word without SDM_CARRY_EN: res_count=0, res_mask=0.
  - An interleaved req1 word does not disturb req0's carried context.
